// File: rtl/uart_char_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_char_source_pkg
// Description : Shared definitions for the UART character source: character
//               width common with the text output controller, receiver FSM
//               state encodings and the default system clock frequency.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_char_source_pkg;

    // Character code width shared with the text output controller.
    localparam int CHAR_ID_LENGTH = 8;

    // Default system clock frequency in Hz.
    localparam int DEFAULT_CLK_FREQ = 100_000_000;

    // Receiver FSM state encodings.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage : uart_char_source_pkg
`default_nettype wire

// File: rtl/uart_char_source_fifo.sv
`default_nettype none
// ============================================================================
// Module      : char_fifo
// Description : Synchronous FIFO for received characters. Pointers carry one
//               extra bit so full and empty can be told apart. A push to a
//               full FIFO is accepted only if a pop happens in the same cycle;
//               otherwise it is ignored.
// Ports       : clk   - clock (rising edge)
//               reset - synchronous active-high reset (empties the FIFO)
//               push  - write din this cycle
//               din   - write data
//               pop   - read-advance this cycle (ignored when empty)
//               dout  - head entry (valid while empty=0)
//               full  - no free entries
//               empty - no stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of 2, at least 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // The pop frees the head slot first, so a simultaneous push into a full
    // FIFO lands in the slot being vacated.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= din;
        end
    end

endmodule : char_fifo
`default_nettype wire

// File: rtl/uart_char_source.sv
`default_nettype none
// ============================================================================
// Module      : uart_char_source
// Description : 8N1 UART receiver producing a character stream for the text
//               output controller. Validated bytes are buffered in a small
//               FIFO and released as single-cycle write strobes separated by
//               at least WE_GAP clock cycles.
// Ports       : clk       - system clock (rising edge)
//               reset     - synchronous active-high reset
//               rx        - asynchronous UART line, idles high
//               cout      - character code, valid with we, held afterwards
//               we        - one-cycle write strobe
//               frame_err - one-cycle pulse on a low stop bit
//               overflow  - sticky flag: a byte was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module uart_char_source
    import uart_char_source_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int WE_GAP     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [CHAR_ID_LENGTH-1:0] cout,
    output logic                      we,
    output logic                      frame_err,
    output logic                      overflow
);

    localparam int c_DIV     = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_TW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_SW      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_BW      = $clog2(CHAR_ID_LENGTH);
    localparam int c_GW      = (WE_GAP > 1) ? $clog2(WE_GAP + 1) : 1;

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);
    localparam logic [c_SW-1:0] c_SC_MID    = c_SW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SW-1:0] c_SC_LAST   = c_SW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(CHAR_ID_LENGTH - 1);
    localparam logic [c_GW-1:0] c_GAP_LOAD  = c_GW'(WE_GAP - 1);

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Free-running oversample tick; never realigned to a frame, so the
    // start-edge detection uncertainty is one tick period.
    // ------------------------------------------------------------------
    logic [c_TW-1:0] r_tick_cnt;
    logic            w_tick;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t                 r_state,  w_state_nxt;
    logic [c_SW-1:0]           r_sc,     w_sc_nxt;
    logic [c_BW-1:0]           r_bit,    w_bit_nxt;
    logic [CHAR_ID_LENGTH-1:0] r_shreg,  w_shreg_nxt;
    logic                      w_push_nxt;
    logic                      w_ferr_nxt;

    // Registered push: the FIFO write happens on the edge after the stop
    // bit is sampled.
    logic                      r_push;
    logic [CHAR_ID_LENGTH-1:0] r_push_data;
    logic                      r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sc        <= '0;
            r_bit       <= '0;
            r_shreg     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sc        <= w_sc_nxt;
            r_bit       <= w_bit_nxt;
            r_shreg     <= w_shreg_nxt;
            r_push      <= w_push_nxt;
            r_push_data <= r_shreg;
            r_frame_err <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sc_nxt    = r_sc;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_push_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rxs) begin
                        w_state_nxt = ST_START;
                        w_sc_nxt    = '0;
                    end
                end

                ST_START: begin
                    if (r_sc == c_SC_MID) begin
                        if (!r_rxs) begin
                            w_state_nxt = ST_DATA;
                            w_sc_nxt    = '0;
                            w_bit_nxt   = '0;
                        end else begin
                            // Start bit did not survive to mid-bit: glitch.
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_sc_nxt = r_sc + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (r_sc == c_SC_LAST) begin
                        w_sc_nxt    = '0;
                        w_shreg_nxt = {r_rxs, r_shreg[CHAR_ID_LENGTH-1:1]};
                        if (r_bit == c_BIT_LAST) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_bit_nxt = r_bit + 1'b1;
                        end
                    end else begin
                        w_sc_nxt = r_sc + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (r_sc == c_SC_LAST) begin
                        w_sc_nxt = '0;
                        if (r_rxs) begin
                            w_push_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = ST_WAIT_HIGH;
                        end
                    end else begin
                        w_sc_nxt = r_sc + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    // A held-low (break) line must not retrigger frames.
                    if (r_rxs) begin
                        w_state_nxt = ST_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    logic [CHAR_ID_LENGTH-1:0] w_fifo_dout;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_pop;
    logic [c_GW-1:0]           r_gap;

    assign w_pop = !w_fifo_empty && (r_gap == '0);

    char_fifo #(
        .WIDTH (CHAR_ID_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (r_push),
        .din   (r_push_data),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Strobe generation with a minimum gap between write strobes
    // ------------------------------------------------------------------
    logic [CHAR_ID_LENGTH-1:0] r_cout;
    logic                      r_we;
    logic                      r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cout     <= '0;
            r_we       <= 1'b0;
            r_gap      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_cout <= w_fifo_dout;
                r_gap  <= c_GAP_LOAD;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
            // A simultaneous pop makes room, so only an unaided full push drops.
            if (r_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cout      = r_cout;
    assign we        = r_we;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule : uart_char_source
`default_nettype wire
